// File: rtl/i2s_pkg.sv
// Shared I2S definitions: sample geometry and width-agnostic Gray-code helpers.
package i2s_pkg;

    localparam int SAMPLE_W = 64;
    localparam int CHAN_W   = 32;
    localparam int GRAY_W   = 32;

    typedef logic [GRAY_W-1:0] gray_word_t;

    typedef struct packed {
        logic [CHAN_W-1:0] left;
        logic [CHAN_W-1:0] right;
    } stereo_t;

    // Callers zero-extend narrower pointers; leading zeros leave both conversions unchanged.
    function automatic gray_word_t bin2gray(input gray_word_t bin_s);
        return bin_s ^ {1'b0, bin_s[GRAY_W-1:1]};
    endfunction

    function automatic gray_word_t gray2bin(input gray_word_t gray_s);
        gray_word_t bin_s;
        bin_s[GRAY_W-1] = gray_s[GRAY_W-1];
        for (int i = GRAY_W - 2; i >= 0; i--) begin
            bin_s[i] = bin_s[i+1] ^ gray_s[i];
        end
        return bin_s;
    endfunction

endpackage

// File: rtl/i2s_sample_fifo_if.sv
// Handshake bundle between the sample producer / I2S transmitter side and the sample FIFO.
interface i2s_sample_fifo_if #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 64,
    parameter int UNDERRUN_W = 16
);
    logic                  wr_en;
    logic [WIDTH-1:0]      wr_data;
    logic                  full;
    logic                  overflow;
    logic [DEPTH_LOG2:0]   wr_level;
    logic                  ready;
    logic [WIDTH-1:0]      sample;
    logic                  sample_ready;
    logic [UNDERRUN_W-1:0] underrun_cnt;

    modport master (
        output wr_en, wr_data, ready,
        input  full, overflow, wr_level, sample, sample_ready, underrun_cnt
    );

    modport slave (
        input  wr_en, wr_data, ready,
        output full, overflow, wr_level, sample, sample_ready, underrun_cnt
    );
endinterface

// File: rtl/i2s_ptr_sync.sv
// Two-flop synchronizer for a Gray-coded FIFO pointer entering the clk domain.
module i2s_ptr_sync #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         aclr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta_r;
    logic [W-1:0] sync_r;

    // Metastability stage followed by the stable output stage.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            meta_r <= '0;
            sync_r <= '0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;
endmodule

// File: rtl/i2s_sample_fifo.sv
// Dual-clock stereo sample FIFO: written on clk, popped on sclk negedge by the I2S transmitter.
module i2s_sample_fifo
    import i2s_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = SAMPLE_W,
    parameter int UNDERRUN_W = 16
) (
    input  logic             clk,
    input  logic             sclk,
    input  logic             aclr,
    i2s_sample_fifo_if.slave bus
);
    localparam int AW    = DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0] mem_r [DEPTH];

    logic [PW-1:0]         wptr_r;
    logic [PW-1:0]         wgray_r;
    logic                  full_r;
    logic                  overflow_r;
    logic [PW-1:0]         wr_level_r;
    logic [PW-1:0]         rgray_sync_s;
    logic [PW-1:0]         rbin_sync_s;
    logic [PW-1:0]         wbin_next_s;
    logic [PW-1:0]         wgray_next_s;
    logic [PW-1:0]         full_cmp_s;
    logic                  wr_accept_s;

    logic [PW-1:0]         rptr_r;
    logic [PW-1:0]         rgray_r;
    logic [WIDTH-1:0]      sample_r;
    logic                  sample_ready_r;
    logic [UNDERRUN_W-1:0] underrun_r;
    logic [PW-1:0]         wgray_sync_s;
    logic [PW-1:0]         rptr_inc_s;
    logic                  empty_s;
    logic                  sclk_n_s;

    // Write-side next pointer and the full pattern (read pointer with its top two Gray bits flipped).
    always_comb begin
        wr_accept_s  = bus.wr_en & ~full_r;
        wbin_next_s  = wptr_r + PW'(wr_accept_s);
        wgray_next_s = PW'(bin2gray(GRAY_W'(wbin_next_s)));
        rbin_sync_s  = PW'(gray2bin(GRAY_W'(rgray_sync_s)));
        full_cmp_s   = {~rgray_sync_s[PW-1:PW-2], rgray_sync_s[PW-3:0]};
    end

    // Write pointer, full flag, overflow pulse and occupancy, all in the clk domain.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            wptr_r     <= '0;
            wgray_r    <= '0;
            full_r     <= 1'b0;
            overflow_r <= 1'b0;
            wr_level_r <= '0;
        end else begin
            wptr_r     <= wbin_next_s;
            wgray_r    <= wgray_next_s;
            full_r     <= (wgray_next_s == full_cmp_s);
            overflow_r <= bus.wr_en & full_r;
            wr_level_r <= wbin_next_s - rbin_sync_s;
        end
    end

    // Storage is not reset; stale words are never visible because both pointers clear together.
    always_ff @(posedge clk) begin
        if (wr_accept_s) begin
            mem_r[wptr_r[AW-1:0]] <= bus.wr_data;
        end
    end

    assign sclk_n_s   = ~sclk;
    assign empty_s    = (rgray_r == wgray_sync_s);
    assign rptr_inc_s = rptr_r + PW'(1'b1);

    // Pop on a ready pulse; outputs hold between pulses so the transmitter can load at leisure.
    always_ff @(negedge sclk or posedge aclr) begin
        if (aclr) begin
            rptr_r         <= '0;
            rgray_r        <= '0;
            sample_r       <= '0;
            sample_ready_r <= 1'b0;
            underrun_r     <= '0;
        end else if (bus.ready) begin
            if (!empty_s) begin
                sample_r       <= mem_r[rptr_r[AW-1:0]];
                sample_ready_r <= 1'b1;
                rptr_r         <= rptr_inc_s;
                rgray_r        <= PW'(bin2gray(GRAY_W'(rptr_inc_s)));
            end else begin
                sample_r       <= '0;
                sample_ready_r <= 1'b0;
                if (underrun_r != '1) begin
                    underrun_r <= underrun_r + UNDERRUN_W'(1'b1);
                end
            end
        end
    end

    i2s_ptr_sync #(.W(PW)) u_rptr_sync (
        .clk  (clk),
        .aclr (aclr),
        .d    (rgray_r),
        .q    (rgray_sync_s)
    );

    i2s_ptr_sync #(.W(PW)) u_wptr_sync (
        .clk  (sclk_n_s),
        .aclr (aclr),
        .d    (wgray_r),
        .q    (wgray_sync_s)
    );

    assign bus.full         = full_r;
    assign bus.overflow     = overflow_r;
    assign bus.wr_level     = wr_level_r;
    assign bus.sample       = sample_r;
    assign bus.sample_ready = sample_ready_r;
    assign bus.underrun_cnt = underrun_r;
endmodule

// File: tb/tb_i2s_sample_fifo.sv
// Scoreboard bench for i2s_sample_fifo: words queued on write, compared on each transmitter pop.
module tb_i2s_sample_fifo;
    import i2s_pkg::*;

    localparam int  DL      = 4;
    localparam int  W       = 64;
    localparam int  UW      = 16;
    localparam time VIS_LAT = 1000;

    typedef struct {
        logic [63:0] data;
        time         t;
    } exp_t;

    logic clk  = 1'b0;
    logic sclk = 1'b0;
    logic aclr = 1'b1;

    always #10 clk = ~clk;
    always #163 sclk = ~sclk;

    i2s_sample_fifo_if #(.DEPTH_LOG2(DL), .WIDTH(W), .UNDERRUN_W(UW)) bus ();
    i2s_sample_fifo_if #(.DEPTH_LOG2(DL), .WIDTH(W), .UNDERRUN_W(4))  sbus ();

    i2s_sample_fifo #(.DEPTH_LOG2(DL), .WIDTH(W), .UNDERRUN_W(UW)) u_dut (
        .clk (clk), .sclk (sclk), .aclr (aclr), .bus (bus)
    );

    i2s_sample_fifo #(.DEPTH_LOG2(DL), .WIDTH(W), .UNDERRUN_W(4)) u_sat (
        .clk (clk), .sclk (sclk), .aclr (aclr), .bus (sbus)
    );

    exp_t q[$];
    int   checks    = 0;
    int   errors    = 0;
    int   pop_cnt   = 0;
    int   exp_under = 0;
    time  mon_t;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_word(input logic [63:0] d, input logic exp_full);
        @(negedge clk);
        check_eq("full_pre", 64'(bus.full), 64'(exp_full));
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        @(negedge clk);
        bus.wr_en = 1'b0;
        check_eq("overflow", 64'(bus.overflow), 64'(exp_full));
        if (!exp_full) begin
            q.push_back('{d, $time - 10});
        end
    endtask

    task automatic pop_once();
        @(posedge sclk);
        bus.ready = 1'b1;
        @(posedge sclk);
        bus.ready = 1'b0;
        @(posedge sclk);
    endtask

    task automatic eval_pop(input time tp);
        logic must_data;
        must_data = (q.size() > 0) && (q[0].t + VIS_LAT <= tp);
        if (bus.sample_ready) begin
            if (q.size() == 0) begin
                check_eq("pop_spurious", 64'(bus.sample_ready), 64'd0);
            end else begin
                check_eq("pop_data", bus.sample, q[0].data);
                void'(q.pop_front());
                pop_cnt++;
            end
        end else begin
            if (must_data) begin
                check_eq("pop_ready", 64'(bus.sample_ready), 64'd1);
            end
            check_eq("pop_zero", bus.sample, 64'd0);
            exp_under++;
        end
        check_eq("underrun", 64'(bus.underrun_cnt), 64'(exp_under));
    endtask

    task automatic check_reset_state();
        check_eq("rst_full",     64'(bus.full),         64'd0);
        check_eq("rst_overflow", 64'(bus.overflow),     64'd0);
        check_eq("rst_level",    64'(bus.wr_level),     64'd0);
        check_eq("rst_sample",   bus.sample,            64'd0);
        check_eq("rst_srdy",     64'(bus.sample_ready), 64'd0);
        check_eq("rst_underrun", 64'(bus.underrun_cnt), 64'd0);
    endtask

    // Pop monitor: a ready pulse seen on a negedge is judged at the following posedge.
    initial begin
        forever begin
            @(negedge sclk);
            if (bus.ready === 1'b1 && aclr === 1'b0) begin
                mon_t = $time;
                @(posedge sclk);
                eval_pop(mon_t);
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          base_pop;
        int          under_before;
        int          written;
        logic [31:0] idx;
        bus.wr_en    = 1'b0;
        bus.wr_data  = '0;
        bus.ready    = 1'b0;
        sbus.wr_en   = 1'b0;
        sbus.wr_data = '0;
        sbus.ready   = 1'b0;

        #3;
        check_reset_state();
        repeat (3) @(negedge clk);
        aclr = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(posedge sclk);
            sbus.ready = 1'b1;
            @(posedge sclk);
            sbus.ready = 1'b0;
            check_eq("sat_cnt", 64'(sbus.underrun_cnt), (i + 1 < 15) ? 64'(i + 1) : 64'd15);
            check_eq("sat_srdy", 64'(sbus.sample_ready), 64'd0);
        end

        push_word(64'h1111_0000_0000_0001, 1'b0);
        push_word(64'h2222_0000_0000_0002, 1'b0);
        push_word(64'h3333_0000_0000_0003, 1'b0);
        repeat (60) @(negedge clk);
        check_eq("order_level", 64'(bus.wr_level), 64'd3);
        repeat (4) pop_once();
        check_eq("order_udr", 64'(bus.underrun_cnt), 64'd1);

        for (int i = 0; i < 16; i++) begin
            push_word({32'hF000_0000 + 32'(i), 32'h0BAD_0000 + 32'(i)}, 1'b0);
        end
        repeat (60) @(negedge clk);
        check_eq("full_set",   64'(bus.full),     64'd1);
        check_eq("full_level", 64'(bus.wr_level), 64'd16);
        push_word(64'hDEAD_DEAD_DEAD_DEAD, 1'b1);
        @(posedge sclk);
        bus.ready = 1'b1;
        @(negedge sclk);
        for (int k = 0; k < 4 && bus.full; k++) @(negedge clk);
        check_eq("full_clr", 64'(bus.full), 64'd0);
        @(posedge sclk);
        bus.ready = 1'b0;
        @(posedge sclk);
        repeat (5) @(negedge clk);
        check_eq("full_lvl15", 64'(bus.wr_level), 64'd15);
        repeat (15) pop_once();

        under_before = exp_under;
        base_pop     = pop_cnt;
        written      = 0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    for (int g = 0; g < 20000 && q.size() >= 10; g++) @(negedge clk);
                    idx = 32'(i);
                    push_word({32'hC0DE_0000 | idx, ~idx}, 1'b0);
                    written++;
                end
            end
            begin
                for (int g = 0; g < 2000 && q.size() < 8; g++) @(negedge clk);
                repeat (60) @(negedge clk);
                for (int n = 0; n < 400 && (pop_cnt - base_pop) < 200; n++) begin
                    @(posedge sclk);
                    bus.ready = 1'b1;
                    @(posedge sclk);
                    bus.ready = 1'b0;
                    repeat (6) @(posedge sclk);
                end
            end
        join
        check_eq("stream_cnt", 64'(pop_cnt - base_pop), 64'd200);
        check_eq("stream_udr", 64'(bus.underrun_cnt), 64'(under_before));

        push_word(64'hC011_0000_0000_0001, 1'b0);
        repeat (60) @(negedge clk);
        fork
            begin
                @(posedge sclk);
                bus.ready = 1'b1;
                @(posedge sclk);
                bus.ready = 1'b0;
            end
            begin
                @(posedge sclk);
                #150;
                push_word(64'hC011_0000_0000_0002, 1'b0);
            end
        join
        repeat (60) @(negedge clk);
        pop_once();
        repeat (10) @(negedge clk);
        check_eq("coll1_level", 64'(bus.wr_level), 64'd0);

        for (int i = 0; i < 16; i++) begin
            push_word({32'hC016_0000, 32'(i)}, 1'b0);
        end
        repeat (60) @(negedge clk);
        fork
            begin
                @(posedge sclk);
                bus.ready = 1'b1;
                @(posedge sclk);
                bus.ready = 1'b0;
            end
            begin
                @(posedge sclk);
                #150;
                push_word(64'hC016_DEAD_DEAD_DEAD, 1'b1);
            end
        join
        repeat (15) pop_once();
        repeat (10) @(negedge clk);
        check_eq("coll16_level", 64'(bus.wr_level), 64'd0);

        for (int i = 0; i < 5; i++) begin
            push_word({32'h5E70_0000, 32'(i)}, 1'b0);
        end
        repeat (60) @(negedge clk);
        check_eq("pre_rst_level", 64'(bus.wr_level), 64'd5);
        #7;
        aclr = 1'b1;
        #1;
        check_reset_state();
        q.delete();
        exp_under = 0;
        repeat (3) @(negedge clk);
        aclr = 1'b0;
        push_word(64'h0000_0000_0000_00A1, 1'b0);
        repeat (60) @(negedge clk);
        pop_once();
        check_eq("post_rst_udr", 64'(bus.underrun_cnt), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
